// File: rtl/sim_monitor_if.sv
// sim_monitor_if: commit-lane bus from the core and trace-record bus to the log drainer.
//   master : core/drainer side (drives commits and rec_ready_i, receives the head record)
//   slave  : sim_monitor side (receives commits, presents the head record)
//   cm_valid_i/cm_pc_i/cm_ir_i/cm_we_i/cm_addr_i/cm_wdata_i : NCH commit lanes, lane 0 oldest
//   rec_valid_o/rec_ready_i/rec_ch_o/rec_pc_o/rec_ir_o      : FIFO head handshake and payload
interface sim_monitor_if #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned NCH  = 2
) ();
   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

   logic [NCH-1:0]            cm_valid_i;
   logic [NCH-1:0][XLEN-1:0]  cm_pc_i;
   logic [NCH-1:0][31:0]      cm_ir_i;
   logic [NCH-1:0]            cm_we_i;
   logic [NCH-1:0][XLEN-1:0]  cm_addr_i;
   logic [NCH-1:0][XLEN-1:0]  cm_wdata_i;

   logic                      rec_valid_o;
   logic                      rec_ready_i;
   logic [CHW-1:0]            rec_ch_o;
   logic [XLEN-1:0]           rec_pc_o;
   logic [31:0]               rec_ir_o;

   modport master (
      output cm_valid_i, cm_pc_i, cm_ir_i, cm_we_i, cm_addr_i, cm_wdata_i, rec_ready_i,
      input  rec_valid_o, rec_ch_o, rec_pc_o, rec_ir_o
   );

   modport slave (
      input  cm_valid_i, cm_pc_i, cm_ir_i, cm_we_i, cm_addr_i, cm_wdata_i, rec_ready_i,
      output rec_valid_o, rec_ch_o, rec_pc_o, rec_ir_o
   );
endinterface

// File: rtl/sim_monitor.sv
// sim_monitor: simulation commit monitor. Counts cycles/retired instructions, buffers
// per-lane commit records in a multi-write FIFO and decides end of simulation
// (tohost, UNIMP, timeout, optional no-commit stall), draining the FIFO before halt.
//   clk_i, rst_ni  : clock, synchronous active-low reset
//   max_cycles_i   : timeout limit, 0 disables
//   bus            : sim_monitor_if.slave (commit lanes in, trace head out)
//   overflow_o     : sticky record-drop flag
//   cycle_o, instret_o : counters
//   status_o       : 0 RUN, 1 PASS, 2 FAIL, 3 UNIMP, 4 TIMEOUT, 5 STALL
//   exit_code_o    : tohost payload >> 1
//   halt_o         : simulation may finish
// Optional feature macro: SIM_MONITOR_STALL_WATCHDOG_EN (stall counter and STALL cause).
module sim_monitor #(
   parameter int unsigned     XLEN        = 64,
   parameter int unsigned     NCH         = 2,
   parameter int unsigned     DEPTH       = 16,
   parameter logic [XLEN-1:0] TOHOST_ADDR = XLEN'(64'h8000_1000),
   parameter int unsigned     STALL_LIMIT = 4096
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic [63:0]       max_cycles_i,
   sim_monitor_if.slave      bus,
   output logic              overflow_o,
   output logic [63:0]       cycle_o,
   output logic [63:0]       instret_o,
   output logic [2:0]        status_o,
   output logic [XLEN-1:0]   exit_code_o,
   output logic              halt_o
);
   localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned PW  = AW + 1;

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_HALT  = 2'd2;

   localparam logic [2:0] ST_RUN     = 3'd0;
   localparam logic [2:0] ST_PASS    = 3'd1;
   localparam logic [2:0] ST_FAIL    = 3'd2;
   localparam logic [2:0] ST_UNIMP   = 3'd3;
   localparam logic [2:0] ST_TIMEOUT = 3'd4;
   localparam logic [2:0] ST_STALL   = 3'd5;

   localparam logic [31:0] UNIMP_IR = 32'hc0001073;

   logic [1:0]             state, state_nxt;
   logic [2:0]             status_nxt;
   logic [XLEN-1:0]        code_nxt;
   logic                   halt_nxt;

   logic [NCH-1:0]         accept;
   logic                   end_lane, end_tohost;
   logic [2:0]             lane_status;
   logic [XLEN-1:0]        lane_code;
   logic                   stall_hit;

   logic [PW-1:0]          wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
   logic [PW-1:0]          count, free, n_acc, n_push;
   logic [NCH-1:0]         push;
   logic [NCH-1:0][AW-1:0] slot;
   logic                   pop, drop;

   logic [CHW-1:0]         mem_ch [DEPTH];
   logic [XLEN-1:0]        mem_pc [DEPTH];
   logic [31:0]            mem_ir [DEPTH];
   logic [CHW-1:0]         head_ch;
   logic [XLEN-1:0]        head_pc;
   logic [31:0]            head_ir;

   // Lane scan: accept valid lanes in order until one of them ends the run
   always_comb begin
      accept      = '0;
      end_lane    = 1'b0;
      end_tohost  = 1'b0;
      lane_status = ST_RUN;
      lane_code   = '0;
      for (int k = 0; k < NCH; k++) begin
         if (state == S_RUN && bus.cm_valid_i[k] && !end_lane) begin
            accept[k] = 1'b1;
            if (bus.cm_we_i[k] && bus.cm_addr_i[k] == TOHOST_ADDR && bus.cm_wdata_i[k][0]) begin
               end_lane    = 1'b1;
               end_tohost  = 1'b1;
               lane_code   = bus.cm_wdata_i[k] >> 1;
               lane_status = (lane_code == '0) ? ST_PASS : ST_FAIL;
            end else if (bus.cm_ir_i[k] == UNIMP_IR) begin
               end_lane    = 1'b1;
               lane_status = ST_UNIMP;
            end
         end
      end
   end

   // FIFO push allocation; free space is taken before this cycle's pop
   always_comb begin
      count  = wr_ptr - rd_ptr;
      free   = PW'(DEPTH) - count;
      pop    = bus.rec_valid_o && bus.rec_ready_i;
      push   = '0;
      slot   = '0;
      n_acc  = '0;
      n_push = '0;
      for (int k = 0; k < NCH; k++) begin
         if (accept[k]) begin
            if (n_acc < free) begin
               push[k] = 1'b1;
               slot[k] = AW'(wr_ptr + n_push);
               n_push  = n_push + PW'(1);
            end
            n_acc = n_acc + PW'(1);
         end
      end
      drop       = (n_acc > free);
      wr_ptr_nxt = wr_ptr + n_push;
      rd_ptr_nxt = rd_ptr + PW'(pop);
   end

   // Next head record, bypassing a slot written this cycle
   always_comb begin
      head_ch = mem_ch[rd_ptr_nxt[AW-1:0]];
      head_pc = mem_pc[rd_ptr_nxt[AW-1:0]];
      head_ir = mem_ir[rd_ptr_nxt[AW-1:0]];
      for (int k = 0; k < NCH; k++) begin
         if (push[k] && slot[k] == rd_ptr_nxt[AW-1:0]) begin
            head_ch = CHW'(k);
            head_pc = bus.cm_pc_i[k];
            head_ir = bus.cm_ir_i[k];
         end
      end
   end

`ifdef SIM_MONITOR_STALL_WATCHDOG_EN
   localparam int unsigned SCW = $clog2(STALL_LIMIT + 1);
   logic [SCW-1:0] stall_cnt;

   // Idle-cycle counter, saturating at the limit
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stall_cnt <= '0;
      end else if (|accept) begin
         stall_cnt <= '0;
      end else if (state == S_RUN && stall_cnt != SCW'(STALL_LIMIT)) begin
         stall_cnt <= stall_cnt + SCW'(1);
      end
   end

   assign stall_hit = (stall_cnt == SCW'(STALL_LIMIT));
`else
   logic unused_stall_limit;
   assign unused_stall_limit = (STALL_LIMIT == 0);
   assign stall_hit          = 1'b0;
`endif

   // Next state and next registered status outputs
   always_comb begin
      state_nxt  = state;
      status_nxt = status_o;
      code_nxt   = exit_code_o;
      halt_nxt   = 1'b0;
      case (state)
         S_RUN: begin
            if (end_lane) begin
               state_nxt  = S_DRAIN;
               status_nxt = lane_status;
               if (end_tohost) code_nxt = lane_code;
            end else if (stall_hit) begin
               state_nxt  = S_DRAIN;
               status_nxt = ST_STALL;
            end else if (max_cycles_i != 64'd0 && cycle_o >= max_cycles_i) begin
               state_nxt  = S_DRAIN;
               status_nxt = ST_TIMEOUT;
            end
         end
         S_DRAIN: begin
            if (count == '0) begin
               state_nxt = S_HALT;
               halt_nxt  = 1'b1;
            end
         end
         S_HALT:  halt_nxt  = 1'b1;
         default: state_nxt = S_RUN;
      endcase
   end

   // Record storage; contents need no reset, pointers define validity
   always_ff @(posedge clk_i) begin
      for (int k = 0; k < NCH; k++) begin
         if (push[k]) begin
            mem_ch[slot[k]] <= CHW'(k);
            mem_pc[slot[k]] <= bus.cm_pc_i[k];
            mem_ir[slot[k]] <= bus.cm_ir_i[k];
         end
      end
   end

   // State, pointers, counters and registered outputs
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state           <= S_RUN;
         wr_ptr          <= '0;
         rd_ptr          <= '0;
         bus.rec_valid_o <= 1'b0;
         bus.rec_ch_o    <= '0;
         bus.rec_pc_o    <= '0;
         bus.rec_ir_o    <= '0;
         overflow_o      <= 1'b0;
         cycle_o         <= '0;
         instret_o       <= '0;
         status_o        <= ST_RUN;
         exit_code_o     <= '0;
         halt_o          <= 1'b0;
      end else begin
         state           <= state_nxt;
         wr_ptr          <= wr_ptr_nxt;
         rd_ptr          <= rd_ptr_nxt;
         bus.rec_valid_o <= (wr_ptr_nxt != rd_ptr_nxt);
         bus.rec_ch_o    <= head_ch;
         bus.rec_pc_o    <= head_pc;
         bus.rec_ir_o    <= head_ir;
         overflow_o      <= overflow_o | drop;
         if (state != S_HALT) cycle_o <= cycle_o + 64'd1;
         instret_o       <= instret_o + 64'(n_acc);
         status_o        <= status_nxt;
         exit_code_o     <= code_nxt;
         halt_o          <= halt_nxt;
      end
   end
endmodule

// File: tb/tb_sim_monitor.sv
// tb_sim_monitor: self-checking bench for sim_monitor. A DEPTH=16 instance runs the
// commit/end-cause vector table and sequences; a DEPTH=4 instance covers overflow.
// Expected trace records go into per-instance queues and are compared on each pop.
module tb_sim_monitor;
   localparam int unsigned XLEN   = 64;
   localparam int unsigned NCH    = 2;
   localparam logic [63:0] TOHOST = 64'h8000_1000;
   localparam logic [31:0] ADDI   = 32'h00108093;
   localparam logic [31:0] SD     = 32'h00a13023;
   localparam logic [31:0] UNIMP  = 32'hc0001073;

   typedef struct packed {
      logic [0:0]  ch;
      logic [63:0] pc;
      logic [31:0] ir;
   } rec_t;

   typedef struct {
      string       name;
      logic [1:0]  valid;
      logic [1:0]  we;
      logic [31:0] ir0, ir1;
      logic [63:0] addr0, wd0, addr1, wd1;
      int          n_acc;
      logic [2:0]  status;
      logic [63:0] code;
   } vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, srst_n;
   logic [63:0] max_cycles, smax_cycles;
   logic        overflow, s_overflow, halt, s_halt;
   logic [63:0] cycle, instret, exit_code, s_cycle, s_instret, s_exit_code;
   logic [2:0]  status, s_status;

   sim_monitor_if #(.XLEN(XLEN), .NCH(NCH)) mbus ();
   sim_monitor_if #(.XLEN(XLEN), .NCH(NCH)) sbus ();

   sim_monitor #(.XLEN(XLEN), .NCH(NCH), .DEPTH(16), .TOHOST_ADDR(TOHOST), .STALL_LIMIT(16)) dut (
      .clk_i(clk), .rst_ni(rst_n), .max_cycles_i(max_cycles), .bus(mbus),
      .overflow_o(overflow), .cycle_o(cycle), .instret_o(instret), .status_o(status),
      .exit_code_o(exit_code), .halt_o(halt)
   );

   sim_monitor #(.XLEN(XLEN), .NCH(NCH), .DEPTH(4), .TOHOST_ADDR(TOHOST), .STALL_LIMIT(4096)) sdut (
      .clk_i(clk), .rst_ni(srst_n), .max_cycles_i(smax_cycles), .bus(sbus),
      .overflow_o(s_overflow), .cycle_o(s_cycle), .instret_o(s_instret), .status_o(s_status),
      .exit_code_o(s_exit_code), .halt_o(s_halt)
   );

   int   errors = 0;
   int   checks = 0;
   int   m_pops = 0;
   int   s_pops = 0;
   rec_t mq[$];
   rec_t sq[$];
   vec_t vecs[10];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic vec_t mkv(input string n, input logic [1:0] v, input logic [1:0] we,
                                input logic [31:0] i0, input logic [31:0] i1,
                                input logic [63:0] a0, input logic [63:0] d0,
                                input logic [63:0] a1, input logic [63:0] d1,
                                input int na, input logic [2:0] st, input logic [63:0] cd);
      vec_t r;
      r.name = n; r.valid = v; r.we = we; r.ir0 = i0; r.ir1 = i1;
      r.addr0 = a0; r.wd0 = d0; r.addr1 = a1; r.wd1 = d1;
      r.n_acc = na; r.status = st; r.code = cd;
      return r;
   endfunction

   task automatic mdrive(input logic [1:0] v, input logic [1:0] we,
                         input logic [63:0] pc0, input logic [63:0] pc1,
                         input logic [31:0] i0, input logic [31:0] i1,
                         input logic [63:0] a0, input logic [63:0] d0,
                         input logic [63:0] a1, input logic [63:0] d1);
      mbus.cm_valid_i = v;     mbus.cm_we_i = we;
      mbus.cm_pc_i[0] = pc0;   mbus.cm_pc_i[1] = pc1;
      mbus.cm_ir_i[0] = i0;    mbus.cm_ir_i[1] = i1;
      mbus.cm_addr_i[0] = a0;  mbus.cm_addr_i[1] = a1;
      mbus.cm_wdata_i[0] = d0; mbus.cm_wdata_i[1] = d1;
   endtask

   task automatic sdrive(input logic [1:0] v, input logic [63:0] pc0, input logic [63:0] pc1);
      sbus.cm_valid_i = v;    sbus.cm_we_i = 2'b00;
      sbus.cm_pc_i[0] = pc0;  sbus.cm_pc_i[1] = pc1;
      sbus.cm_ir_i[0] = ADDI; sbus.cm_ir_i[1] = ADDI;
      sbus.cm_addr_i = '0;    sbus.cm_wdata_i = '0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_status"}, 64'(status), 64'd0);
      check({tag, "_halt"}, 64'(halt), 64'd0);
      check({tag, "_rec_valid"}, 64'(mbus.rec_valid_o), 64'd0);
      check({tag, "_overflow"}, 64'(overflow), 64'd0);
      check({tag, "_cycle"}, cycle, 64'd0);
      check({tag, "_instret"}, instret, 64'd0);
      check({tag, "_exit_code"}, exit_code, 64'd0);
   endtask

   // Main-instance scoreboard: compare each popped head record with the oldest expected one
   always @(negedge clk) begin
      rec_t e;
      if (mbus.rec_valid_o === 1'b1 && mbus.rec_ready_i === 1'b1) begin
         m_pops++;
         if (mq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL main_rec_unexpected: got pc 0x%0h ch %0d, expected no record",
                     mbus.rec_pc_o, mbus.rec_ch_o);
         end else begin
            e = mq.pop_front();
            check("main_rec_ch", 64'(mbus.rec_ch_o), 64'(e.ch));
            check("main_rec_pc", mbus.rec_pc_o, e.pc);
            check("main_rec_ir", 64'(mbus.rec_ir_o), 64'(e.ir));
         end
      end
   end

   // Small-instance scoreboard
   always @(negedge clk) begin
      rec_t e;
      if (sbus.rec_valid_o === 1'b1 && sbus.rec_ready_i === 1'b1) begin
         s_pops++;
         if (sq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL small_rec_unexpected: got pc 0x%0h, expected no record", sbus.rec_pc_o);
         end else begin
            e = sq.pop_front();
            check("small_rec_ch", 64'(sbus.rec_ch_o), 64'(e.ch));
            check("small_rec_pc", sbus.rec_pc_o, e.pc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the summary in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [2:0]  exp_end;
      logic [63:0] exp_cyc;
      int          found;
      int          pushed;

      vecs[0] = mkv("dual_addi", 2'b11, 2'b00, ADDI, ADDI, 0, 0, 0, 0, 2, 3'd0, 0);
      vecs[1] = mkv("tohost_pass_l0", 2'b11, 2'b01, SD, ADDI, TOHOST, 1, 0, 0, 1, 3'd1, 0);
      vecs[2] = mkv("tohost_fail7", 2'b01, 2'b01, SD, ADDI, TOHOST, 7, 0, 0, 1, 3'd2, 3);
      vecs[3] = mkv("unimp_l1", 2'b11, 2'b00, ADDI, UNIMP, 0, 0, 0, 0, 2, 3'd3, 0);
      vecs[4] = mkv("unimp_l0", 2'b11, 2'b00, UNIMP, ADDI, 0, 0, 0, 0, 1, 3'd3, 0);
      vecs[5] = mkv("tohost_bit0_clear", 2'b11, 2'b01, SD, ADDI, TOHOST, 6, 0, 0, 2, 3'd0, 0);
      vecs[6] = mkv("store_other_addr", 2'b11, 2'b10, ADDI, SD, 0, 0, TOHOST + 8, 1, 2, 3'd0, 0);
      vecs[7] = mkv("l1_tohost_fail", 2'b11, 2'b10, ADDI, SD, 0, 0, TOHOST, 64'h2b, 2, 3'd2, 64'h15);
      vecs[8] = mkv("l1_only_unimp", 2'b10, 2'b00, ADDI, UNIMP, 0, 0, 0, 0, 1, 3'd3, 0);
      vecs[9] = mkv("we_lane_invalid", 2'b01, 2'b10, ADDI, SD, 0, 0, TOHOST, 1, 1, 3'd0, 0);

      rst_n = 1'b0; srst_n = 1'b0; max_cycles = '0; smax_cycles = '0;
      mdrive(2'b00, 2'b00, 0, 0, ADDI, ADDI, 0, 0, 0, 0);
      sdrive(2'b00, 0, 0);
      mbus.rec_ready_i = 1'b0; sbus.rec_ready_i = 1'b0;
      tick(); tick();
      check_reset_values("reset");

      // Four cycles of dual addi commits, drained continuously
      rst_n = 1'b1; mbus.rec_ready_i = 1'b1; m_pops = 0;
      for (int c = 0; c < 4; c++) begin
         mdrive(2'b11, 2'b00, 64'h1000, 64'h1004, ADDI, ADDI, 0, 0, 0, 0);
         mq.push_back('{ch: 1'b0, pc: 64'h1000, ir: ADDI});
         mq.push_back('{ch: 1'b1, pc: 64'h1004, ir: ADDI});
         tick();
      end
      mdrive(2'b00, 2'b00, 0, 0, ADDI, ADDI, 0, 0, 0, 0);
      repeat (12) tick();
      check("stream_instret", instret, 64'd8);
      check("stream_records", 64'(m_pops), 64'd8);
      check("stream_overflow", 64'(overflow), 64'd0);
      check("stream_status", 64'(status), 64'd0);
      check("stream_queue_left", 64'(mq.size()), 64'd0);

      // Table of single-cycle commit patterns
      for (int i = 0; i < 10; i++) begin
         rst_n = 1'b0; tick(); rst_n = 1'b1;
         m_pops = 0; pushed = 0;
         mdrive(vecs[i].valid, vecs[i].we, 64'h1000 + 64'(i * 16), 64'h1004 + 64'(i * 16),
                vecs[i].ir0, vecs[i].ir1, vecs[i].addr0, vecs[i].wd0, vecs[i].addr1, vecs[i].wd1);
         for (int k = 0; k < 2; k++) begin
            if (vecs[i].valid[k] && pushed < vecs[i].n_acc) begin
               mq.push_back('{ch: 1'(k), pc: 64'h1000 + 64'(i * 16) + 64'(k * 4),
                              ir: (k == 0) ? vecs[i].ir0 : vecs[i].ir1});
               pushed++;
            end
         end
         tick();
         mdrive(2'b00, 2'b00, 0, 0, ADDI, ADDI, 0, 0, 0, 0);
         tick();
         check($sformatf("v%0d_%s_status", i, vecs[i].name), 64'(status), 64'(vecs[i].status));
         check($sformatf("v%0d_%s_exit", i, vecs[i].name), exit_code, vecs[i].code);
         check($sformatf("v%0d_%s_instret", i, vecs[i].name), instret, 64'(vecs[i].n_acc));
         repeat (12) tick();
         check($sformatf("v%0d_%s_halt", i, vecs[i].name), 64'(halt),
               (vecs[i].status != 3'd0) ? 64'd1 : 64'd0);
         check($sformatf("v%0d_%s_records", i, vecs[i].name), 64'(m_pops), 64'(vecs[i].n_acc));
         check($sformatf("v%0d_%s_queue_left", i, vecs[i].name), 64'(mq.size()), 64'd0);
      end

      // Timeout (or stall when the watchdog is built) with no commits
`ifdef SIM_MONITOR_STALL_WATCHDOG_EN
      exp_end = 3'd5; exp_cyc = 64'd17;
`else
      exp_end = 3'd4; exp_cyc = 64'd101;
`endif
      rst_n = 1'b0; max_cycles = 64'd100; tick(); rst_n = 1'b1;
      found = 0;
      for (int w = 0; w < 300; w++) begin
         if (status != 3'd0) begin
            found = 1;
            break;
         end
         tick();
      end
      check("idle_end_seen", 64'(found), 64'd1);
      check("idle_status", 64'(status), 64'(exp_end));
      check("idle_cycle_at_end", cycle, exp_cyc);
      check("idle_halt_before", 64'(halt), 64'd0);
      tick();
      check("idle_halt_next", 64'(halt), 64'd1);
      repeat (3) tick();
      check("idle_cycle_frozen", cycle, exp_cyc + 64'd1);
      max_cycles = '0;

      // Reset while draining a record the drainer never accepts
      rst_n = 1'b0; mbus.rec_ready_i = 1'b0; tick(); rst_n = 1'b1; m_pops = 0;
      mdrive(2'b11, 2'b01, 64'h4000, 64'h4004, SD, ADDI, TOHOST, 64'h7, 0, 0);
      tick();
      mdrive(2'b00, 2'b00, 0, 0, ADDI, ADDI, 0, 0, 0, 0);
      tick(); tick();
      check("drain_status", 64'(status), 64'd2);
      check("drain_exit", exit_code, 64'd3);
      check("drain_halt", 64'(halt), 64'd0);
      check("drain_rec_valid", 64'(mbus.rec_valid_o), 64'd1);
      check("drain_instret", instret, 64'd1);
      rst_n = 1'b0; tick();
      check_reset_values("drain_rst");
      rst_n = 1'b1; mbus.rec_ready_i = 1'b1;
      repeat (4) tick();
      check("drain_rst_discarded", 64'(m_pops), 64'd0);

      // Small FIFO: 3 dual-commit cycles with no drain keep 4 and drop 2
      srst_n = 1'b1; s_pops = 0;
      for (int c = 0; c < 3; c++) begin
         sdrive(2'b11, 64'h2000 + 64'(c * 8), 64'h2004 + 64'(c * 8));
         if (c < 2) begin
            sq.push_back('{ch: 1'b0, pc: 64'h2000 + 64'(c * 8), ir: ADDI});
            sq.push_back('{ch: 1'b1, pc: 64'h2004 + 64'(c * 8), ir: ADDI});
         end
         tick();
      end
      sdrive(2'b00, 0, 0);
      tick();
      check("ovf_flag", 64'(s_overflow), 64'd1);
      check("ovf_instret", s_instret, 64'd6);
      check("ovf_rec_valid", 64'(sbus.rec_valid_o), 64'd1);
      sbus.rec_ready_i = 1'b1;
      repeat (8) tick();
      check("ovf_records", 64'(s_pops), 64'd4);
      check("ovf_queue_left", 64'(sq.size()), 64'd0);
      check("ovf_empty", 64'(sbus.rec_valid_o), 64'd0);
      check("ovf_sticky", 64'(s_overflow), 64'd1);

      // Exactly full is no overflow; a same-cycle pop frees nothing for the pushes
      srst_n = 1'b0; sbus.rec_ready_i = 1'b0; tick(); srst_n = 1'b1; s_pops = 0;
      for (int c = 0; c < 2; c++) begin
         sdrive(2'b11, 64'h3000 + 64'(c * 8), 64'h3004 + 64'(c * 8));
         sq.push_back('{ch: 1'b0, pc: 64'h3000 + 64'(c * 8), ir: ADDI});
         sq.push_back('{ch: 1'b1, pc: 64'h3004 + 64'(c * 8), ir: ADDI});
         tick();
      end
      sdrive(2'b00, 0, 0);
      tick();
      check("full_no_overflow", 64'(s_overflow), 64'd0);
      sbus.rec_ready_i = 1'b1;
      sdrive(2'b11, 64'h3100, 64'h3104);
      tick();
      sdrive(2'b00, 0, 0);
      repeat (8) tick();
      check("popsame_overflow", 64'(s_overflow), 64'd1);
      check("popsame_records", 64'(s_pops), 64'd4);
      check("popsame_queue_left", 64'(sq.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
